wave_pattern_gen: RTL
=====================

# wave_pattern_gen

Sample-pattern generator stage fed by `freq_divider`. On every rising edge of the divided tick `freq_2`, it advances a phase accumulator and emits one `DATA_W`-bit waveform sample (sawtooth, triangle, square or ramp-down) for the downstream DAC/output path. A small IDLE/RUN/DONE FSM supports finite bursts or continuous output. The block runs entirely in the `clk_freq1` domain and treats `freq_2` as a synchronous tick, not as a clock.

## Interface
- `DATA_W`, 8: sample and step width.
- `BURST_W`, 16: burst length counter width.

Ports:
- `clk_freq1`  in  1  system clock; all logic on its rising edge.
- `rst_key1`  in  1  asynchronous, active-high reset.
- `freq_2`  in  1  divided tick from `freq_divider`; synchronous to `clk_freq1`.
- `enable`  in  1  a rising edge starts a run; low level aborts a run.
- `wave_sel`  in  2  waveform: 00 saw, 01 triangle, 10 square, 11 ramp-down.
- `step`  in  DATA_W  accumulator increment per sample; 0 is treated as 1.
- `burst_len`  in  BURST_W  samples per run; 0 means continuous.
- `sample`  out  DATA_W  current sample value.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- Edge detect:
  - `tick = freq_2 & ~freq_2_q`, where `freq_2_q` and `enable_q` are registered copies.
  - `start = enable & ~enable_q`.
- FSM states:
  - IDLE:
    - `start` moves to RUN.
    - At the same edge, latch `wave_sel`, `step` (0→1) and `burst_len`.
    - Clear `acc`, `tri`, `cnt`; set `dir` = up.
    - Input changes during RUN are ignored.
  - RUN:
    - Each `tick` emits one sample and advances state.
    - `enable` = 0 moves to IDLE on the next edge, with no `done`. This takes priority over a simultaneous `tick`: no sample is emitted.
    - If `burst_len` ≠ 0 and this tick emits sample number `burst_len`, move to DONE.
  - DONE: `done` = 1 for one cycle, then unconditionally IDLE. A new run requires a fresh `enable` rising edge.
- Per tick (latched mode):
  - Saw: `sample <= acc`; `acc <= acc + step` mod 2^DATA_W.
  - Ramp-down: `sample <= ~acc`; `acc` advances as for saw.
  - Square: `sample <= {DATA_W{acc[DATA_W-1]}}`; `acc` advances as for saw.
  - Triangle: `sample <= tri`.
    - Up: if `tri > MAX-step` then `tri <= MAX`, `dir <= down`; else `tri <= tri+step`.
    - Down: if `tri < step` then `tri <= 0`, `dir <= up`; else `tri <= tri-step`.
  - MAX = 2^DATA_W − 1.
- Burst counter `cnt` (BURST_W bits) increments per emitted sample. In continuous mode it wraps freely and is unused.
- `sample` holds its last value through DONE, IDLE and aborts, until the next emitted sample or reset.

## Timing
- Reset values: `sample` = 0, `sample_valid` = 0, `busy` = 0, `done` = 0; FSM = IDLE; `acc` = `tri` = `cnt` = 0; `dir` = up; `freq_2_q` = `enable_q` = 0.
- Start latency: `enable` sampled high (previously low) at edge N gives `busy` = 1 after edge N.
- Sample latency: `freq_2` sampled high (previously low) at edge N while in RUN gives `sample`/`sample_valid` updated after edge N; `sample_valid` is high for exactly one cycle.
- A `freq_2` rising edge in the same cycle as `start` is not a sample tick. The first sample comes from the next `freq_2` rising edge.
- Burst end:
  - The edge that emits the final sample also enters DONE.
  - `done` is high for the following cycle; `busy` drops at that same edge.
  - IDLE follows one cycle later.
- Minimum tick spacing is 2 clocks. `freq_divider` guarantees ≥ 2.
- Reset mid-run: immediate return to all reset values; a pending `done` is lost.

## Configuration
- `WAVE_TRIANGLE_EN` defined: triangle mode, `tri`/`dir` registers and comparators are built.
- Not defined:
  - `wave_sel` 01 behaves exactly as saw (00).
  - `tri`/`dir` logic is not synthesized.
  - All other modes are unchanged.

## Test plan
- Saw burst: DATA_W = 8, `step` = 1, `burst_len` = 4, four `freq_2` ticks → `sample` 0, 1, 2, 3, each with a one-cycle `sample_valid`; `done` pulses once; `busy` falls; `sample` holds 3.
- Triangle turn (`WAVE_TRIANGLE_EN`): `step` = 100, continuous → 0, 100, 200, 255, 155, 55, 0, 100.
- Square/step-zero: `step` = 0 (used as 1), square → 128 samples of 0x00, then 0xFF from sample 129.
- Abort: `enable` dropped after 2 of 10 samples → `busy` = 0 next cycle; no `done`; `sample` holds 1; a later `freq_2` edge produces no `sample_valid`.
- Reset mid-run: `rst_key1` pulsed during RUN → all outputs 0 immediately; a new `enable` edge restarts the saw from 0.
- Ramp-down wrap: `step` = 0x80, continuous → 0xFF, 0x7F, 0xFF, 0x7F; `freq_2` held high does not retrigger.

Source files
------------

// File: rtl/wave_pattern_gen.sv
// Tick-driven waveform sample generator with an IDLE/RUN/DONE burst FSM.
// Define WAVE_TRIANGLE_EN to build triangle mode; otherwise wave_sel 01 plays a sawtooth.
module wave_pattern_gen #(
    parameter int DATA_W  = 8,
    parameter int BURST_W = 16
) (
    input  logic               clk_freq1,
    input  logic               rst_key1,
    input  logic               freq_2,
    input  logic               enable,
    input  logic [1:0]         wave_sel,
    input  logic [DATA_W-1:0]  step,
    input  logic [BURST_W-1:0] burst_len,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               done
);
    localparam logic [DATA_W-1:0] MAX_VAL = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic               freq_2_q, enable_q;
    logic               tick, start;
    logic               load, emit;
    logic [1:0]         mode_reg, mode_load;
    logic [DATA_W-1:0]  step_reg, acc_reg, sample_reg, wave_sample;
    logic [DATA_W-1:0]  square_bits;
    logic [BURST_W-1:0] burst_reg, cnt_reg, cnt_inc;
    logic               valid_reg;

    assign tick    = freq_2 & ~freq_2_q;
    assign start   = enable & ~enable_q;
    assign cnt_inc = cnt_reg + BURST_W'(1);

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_square
            assign square_bits[gi] = acc_reg[DATA_W-1];
        end
    endgenerate

`ifdef WAVE_TRIANGLE_EN
    logic [DATA_W-1:0] tri_reg, tri_next;
    logic              dir_reg, dir_next;   // 0 = rising, 1 = falling

    assign mode_load = wave_sel;

    always_comb begin
        tri_next = tri_reg;
        dir_next = dir_reg;
        if (!dir_reg) begin
            if (tri_reg > MAX_VAL - step_reg) begin
                tri_next = MAX_VAL;
                dir_next = 1'b1;
            end else begin
                tri_next = tri_reg + step_reg;
            end
        end else begin
            if (tri_reg < step_reg) begin
                tri_next = '0;
                dir_next = 1'b0;
            end else begin
                tri_next = tri_reg - step_reg;
            end
        end
    end

    always_ff @(posedge clk_freq1 or posedge rst_key1) begin
        if (rst_key1) begin
            tri_reg <= '0;
            dir_reg <= 1'b0;
        end else if (load) begin
            tri_reg <= '0;
            dir_reg <= 1'b0;
        end else if (emit) begin
            tri_reg <= tri_next;
            dir_reg <= dir_next;
        end
    end
`else
    // Without the triangle datapath, mode 01 is folded onto the sawtooth at latch time.
    assign mode_load = (wave_sel == 2'b01) ? 2'b00 : wave_sel;
`endif

    always_comb begin
        case (mode_reg)
            2'b10:   wave_sample = square_bits;
            2'b11:   wave_sample = ~acc_reg;
`ifdef WAVE_TRIANGLE_EN
            2'b01:   wave_sample = tri_reg;
`endif
            default: wave_sample = acc_reg;
        endcase
    end

    // Abort (enable low) wins over a tick arriving in the same cycle.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        emit       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    emit = 1'b1;
                    if ((burst_reg != '0) && (cnt_inc == burst_reg))
                        state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_freq1 or posedge rst_key1) begin
        if (rst_key1) begin
            state_reg  <= ST_IDLE;
            freq_2_q   <= 1'b0;
            enable_q   <= 1'b0;
            mode_reg   <= 2'b00;
            step_reg   <= '0;
            burst_reg  <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            sample_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            freq_2_q  <= freq_2;
            enable_q  <= enable;
            valid_reg <= emit;
            if (load) begin
                mode_reg  <= mode_load;
                step_reg  <= (step == '0) ? DATA_W'(1) : step;
                burst_reg <= burst_len;
                acc_reg   <= '0;
                cnt_reg   <= '0;
            end else if (emit) begin
                sample_reg <= wave_sample;
                acc_reg    <= acc_reg + step_reg;
                cnt_reg    <= cnt_inc;
            end
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = valid_reg;
    assign busy         = (state_reg == ST_RUN);
    assign done         = (state_reg == ST_DONE);
endmodule
